// File: rtl/bf_tty.sv
// Text-mode character sink: FIFO-buffered character stream rendered into a
// COLS x ROWS video RAM with LF/CR/BS handling and hardware scroll.
module bf_tty #(
    parameter int         COLS    = 80,
    parameter int         ROWS    = 25,
    parameter int         FIFO_AW = 4,
    parameter logic [7:0] ATTR    = 8'h07
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        print,
    input  logic [7:0]  out,
    output logic        full,
    output logic        lost,
    output logic        busy,
    output logic [11:0] vaddr,
    output logic [15:0] vdata,
    output logic        vwe,
    input  logic [15:0] vdin,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y
);
    localparam logic [11:0] LAST_CELL = 12'(COLS*ROWS - 1);
    localparam logic [11:0] LAST_SCR  = 12'(COLS*(ROWS-1) - 1);
    localparam logic [11:0] LAST_ROW  = 12'(COLS*(ROWS-1));
    localparam logic [11:0] COLS_W    = 12'(COLS);
    localparam logic [11:0] LAST_COL  = 12'(COLS - 1);
    localparam logic [6:0]  XMAX      = 7'(COLS - 1);
    localparam logic [4:0]  YMAX      = 5'(ROWS - 1);
    localparam logic [15:0] BLANK     = {ATTR, 8'h20};

    if (COLS*ROWS > 4096 || COLS > 128 || ROWS > 32) begin : g_bad_geom
        $error("bf_tty: screen geometry does not fit 12-bit addresses / cursor widths");
    end

    typedef enum logic [2:0] {CLRALL, IDLE, EXEC, SCR_RD, SCR_WR, CLRROW} state_t;
    state_t state, nstate;

    logic [7:0]       fifo [2**FIFO_AW];
    logic [FIFO_AW:0] wp, rp;
    logic             empty, push, pop;

    logic [11:0] a, a_d, vaddr_d, row;
    logic [15:0] vdata_q, vdata_d;
    logic        vwe_d, copy, copy_d, is_ctl, adv;
    logic [7:0]  ch;
    logic [6:0]  nx;
    logic [4:0]  ny;

    assign empty = (wp == rp);
    assign full  = (wp[FIFO_AW] != rp[FIFO_AW]) && (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
    assign push  = print && !full;
    assign pop   = (state == IDLE) && !empty;
    assign busy  = (state != IDLE) || !empty;

    always_ff @(posedge clock)
        if (push) fifo[wp[FIFO_AW-1:0]] <= out;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            wp   <= '0;
            rp   <= '0;
            lost <= 1'b0;
        end else begin
            if (push)          wp   <= wp + 1'b1;
            if (pop)           rp   <= rp + 1'b1;
            if (print && full) lost <= 1'b1;
        end

    assign is_ctl = (ch == 8'h0A) || (ch == 8'h0D) || (ch == 8'h08);
    assign adv    = (ch == 8'h0A) || (!is_ctl && cur_x == XMAX);
    assign row    = 12'(cur_y) * COLS_W;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= CLRALL;
        else          state <= nstate;

    always_comb begin
        nstate = state;
        case (state)
            CLRALL: if (a == LAST_CELL) nstate = IDLE;
            IDLE:   if (!empty) nstate = EXEC;
            EXEC:   nstate = (adv && cur_y == YMAX) ? SCR_RD : IDLE;
            SCR_RD: nstate = SCR_WR;
            SCR_WR: nstate = (a == LAST_SCR) ? CLRROW : SCR_RD;
            CLRROW: if (a == LAST_COL) nstate = IDLE;
            default: nstate = CLRALL;
        endcase
    end

    // Outputs are registered; a scroll write forwards vdin straight to vdata
    // because the RAM read issued in SCR_RD only lands in the write cycle.
    always_comb begin
        vwe_d   = 1'b0;
        vaddr_d = vaddr;
        vdata_d = vdata_q;
        copy_d  = 1'b0;
        a_d     = a;
        nx      = cur_x;
        ny      = cur_y;
        case (state)
            CLRALL: begin
                vwe_d   = 1'b1;
                vaddr_d = a;
                vdata_d = BLANK;
                a_d     = (a == LAST_CELL) ? 12'd0 : a + 12'd1;
            end
            EXEC: begin
                a_d = 12'd0;
                case (ch)
                    8'h0A: nx = 7'd0;
                    8'h0D: nx = 7'd0;
                    8'h08: if (cur_x != 7'd0) begin
                        nx      = cur_x - 7'd1;
                        vwe_d   = 1'b1;
                        vaddr_d = row + {5'd0, cur_x - 7'd1};
                        vdata_d = BLANK;
                    end
                    default: begin
                        vwe_d   = 1'b1;
                        vaddr_d = row + {5'd0, cur_x};
                        vdata_d = {ATTR, ch};
                        nx      = (cur_x == XMAX) ? 7'd0 : cur_x + 7'd1;
                    end
                endcase
                if (adv && cur_y != YMAX) ny = cur_y + 5'd1;
            end
            SCR_RD: vaddr_d = a + COLS_W;
            SCR_WR: begin
                vwe_d   = 1'b1;
                vaddr_d = a;
                copy_d  = 1'b1;
                a_d     = (a == LAST_SCR) ? 12'd0 : a + 12'd1;
            end
            CLRROW: begin
                vwe_d   = 1'b1;
                vaddr_d = LAST_ROW + a;
                vdata_d = BLANK;
                a_d     = (a == LAST_COL) ? 12'd0 : a + 12'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            vwe     <= 1'b0;
            vaddr   <= 12'd0;
            vdata_q <= 16'd0;
            copy    <= 1'b0;
            a       <= 12'd0;
            ch      <= 8'd0;
            cur_x   <= 7'd0;
            cur_y   <= 5'd0;
        end else begin
            vwe     <= vwe_d;
            vaddr   <= vaddr_d;
            vdata_q <= vdata_d;
            copy    <= copy_d;
            a       <= a_d;
            cur_x   <= nx;
            cur_y   <= ny;
            if (pop) ch <= fifo[rp[FIFO_AW-1:0]];
        end

    assign vdata = copy ? vdin : vdata_q;
endmodule
